// File: rtl/audio_decimator.sv
// audio_decimator: block-averages DECIM signed 8-bit samples using a rounded
// reciprocal multiply, then saturates to signed 8 bits. Emits a one-cycle
// `ready` strobe per block and flags outputs spaced closer than MIN_GAP cycles.
module audio_decimator #(
    parameter int unsigned DECIM   = 12,
    parameter int unsigned RECIP   = 5461,
    parameter int unsigned MIN_GAP = 4001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_ready,
    input  logic signed [7:0] in_sample,
    output logic signed [7:0] x,
    output logic              ready,
    output logic              overrun
);

    localparam logic [7:0]         LastCnt = 8'(DECIM - 1);
    localparam logic [12:0]        GapMax  = 13'(MIN_GAP);
    // Zero-extended so the reciprocal always acts as a positive multiplier.
    localparam logic signed [31:0] RecipS  = 32'(RECIP);

    logic signed [15:0] acc;
    logic signed [15:0] sum;
    logic [7:0]         cnt;
    logic               s1_valid;
    logic               s2_valid;
    logic signed [31:0] prod;
    logic [12:0]        gap;

    logic signed [15:0] samp_ext;
    logic signed [31:0] rnd;
    logic signed [15:0] r;
    logic signed [7:0]  x_d;

    // Sign extension of the input and stage-2 round/saturate.
    always_comb begin
        samp_ext = $signed({{8{in_sample[7]}}, in_sample});
        rnd      = prod + 32'sd32768;
        r        = 16'(rnd >>> 16);
        if (r > 16'sd127) begin
            x_d = 8'sd127;
        end else if (r < -16'sd128) begin
            x_d = -8'sd128;
        end else begin
            x_d = r[7:0];
        end
    end

    // Accumulate samples; the block's last sample hands the sum to stage 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            cnt      <= '0;
            sum      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_ready && (cnt == LastCnt);
            if (in_ready) begin
                if (cnt == LastCnt) begin
                    sum <= acc + samp_ext;
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc + samp_ext;
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

    // Stage 1: reciprocal multiply.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod     <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                prod <= 32'(sum) * RecipS;
            end
        end
    end

    // Stage 2: register the saturated result and raise the output strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x     <= '0;
            ready <= 1'b0;
        end else begin
            ready <= s2_valid;
            if (s2_valid) begin
                x <= x_d;
            end
        end
    end

    // Spacing monitor: gap counts edges since the last strobe, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap     <= GapMax;
            overrun <= 1'b0;
        end else if (s2_valid) begin
            gap <= 13'd1;
            if (gap < GapMax) begin
                overrun <= 1'b1;
            end
        end else if (gap < GapMax) begin
            gap <= gap + 13'd1;
        end
    end

endmodule

// File: tb/tb_audio_decimator.sv
// Scoreboard bench for audio_decimator: a reference model of the block
// average queues the expected value and output cycle; a monitor pops and checks.
module tb_audio_decimator;

    localparam int DECIM   = 12;
    localparam int RECIP   = 5461;
    localparam int MIN_GAP = 4001;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_ready;
    logic signed [7:0] in_sample;
    logic signed [7:0] x;
    logic              ready;
    logic              overrun;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_sum = 0;
    int   m_cnt = 0;

    audio_decimator #(
        .DECIM  (DECIM),
        .RECIP  (RECIP),
        .MIN_GAP(MIN_GAP)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .in_ready (in_ready),
        .in_sample(in_sample),
        .x        (x),
        .ready    (ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: floor((sum*RECIP + 32768) / 65536), clamped to [-128, 127].
    function automatic int model(input int s);
        longint p;
        longint q;
        p = longint'(s) * RECIP + 32768;
        q = p / 65536;
        if (q * 65536 > p) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("x", int'(x), e.val);
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic strobe(input int s);
        @(negedge clk);
        in_ready  = 1'b1;
        in_sample = 8'(s);
        @(posedge clk);
        #1;
        m_sum += s;
        m_cnt++;
        if (m_cnt == DECIM) begin
            exp_t e;
            e.val = model(m_sum);
            e.cyc = cyc + 2;
            exp_q.push_back(e);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    // Strobe, then idle so the next strobe lands `spacing` edges later.
    task automatic strobe_spaced(input int s, input int spacing);
        strobe(s);
        @(negedge clk);
        in_ready = 1'b0;
        repeat (spacing - 2) @(negedge clk);
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        in_ready = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_ready = 1'b0;
        #1;
        check("rst_x", int'(x), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_overrun", int'(overrun), 0);
        m_sum = 0;
        m_cnt = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_ready  = 1'b0;
        in_sample = '0;
        apply_reset();

        // Constant 100 at 562-cycle spacing.
        for (int i = 0; i < DECIM; i++) strobe_spaced(100, 562);
        drain("const100_drain");
        check("const100_overrun", int'(overrun), 0);

        // Reset mid-block after 5 strobes; the partial block is discarded.
        for (int i = 0; i < 5; i++) strobe_spaced(-70, 10);
        apply_reset();
        for (int i = 0; i < DECIM - 1; i++) strobe_spaced(20, 10);
        repeat (5) @(negedge clk);
        check("post_reset_no_early_ready", exp_q.size(), 0);
        strobe_spaced(20, 10);
        drain("post_reset_drain");

        // Rails and rounding, blocks spaced beyond MIN_GAP.
        apply_reset();
        for (int i = 0; i < DECIM; i++) strobe_spaced(127, 400);
        drain("rail_pos_drain");
        for (int i = 0; i < DECIM; i++) strobe_spaced(-128, 400);
        drain("rail_neg_drain");
        for (int i = 0; i < DECIM; i++) strobe_spaced((i % 2 == 0) ? 127 : -127, 400);
        drain("alt_drain");
        for (int i = 0; i < DECIM; i++) strobe_spaced((i == 0) ? 1 : 0, 400);
        drain("sum1_drain");
        for (int i = 0; i < DECIM; i++) strobe_spaced((i == DECIM - 1) ? 12 : 6, 400);
        drain("sum78_drain");
        check("spaced_overrun", int'(overrun), 0);

        // Overrun: blocks 1200 cycles apart.
        apply_reset();
        for (int i = 0; i < DECIM; i++) strobe_spaced(-33, 100);
        drain("ovr_first_drain");
        check("ovr_before_second", int'(overrun), 0);
        for (int i = 0; i < DECIM; i++) strobe_spaced(45, 100);
        drain("ovr_second_drain");
        check("ovr_after_second", int'(overrun), 1);
        repeat (50) @(negedge clk);
        check("ovr_sticky", int'(overrun), 1);

        // Back-to-back strobes for 36 cycles.
        apply_reset();
        for (int i = 0; i < 3 * DECIM; i++) begin
            if (i < DECIM) strobe(10);
            else if (i < 2 * DECIM) strobe(i * 5 - 100);
            else strobe((i % 3 == 0) ? -120 : 37);
        end
        drain("overlap_drain");
        check("overlap_overrun", int'(overrun), 1);
        apply_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
